regfile_dump_ctrl: RTL and testbench

- Run/scan sequencer for the single-cycle processor and its register file.
- Lets the processor run for a programmed cycle budget, then freezes it.
- Takes over regfile read port A and streams all registers out over a valid/ready interface.
- Sits between the processor's ctrl_readRegA and the regfile; replaces the bench-side read-port hijack with synthesizable control for on-board result dumps.

---
 rtl/regfile_dump_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
// Run/scan sequencer for the single-cycle processor and its register file.
// It lets the processor run for a programmed number of cycles and then
// freezes it. It then takes over regfile read port A and streams every
// register out over a valid/ready interface. This lets results be dumped
// on the board without any bench-side hijack of the read port.
//
// Ports:
//   clock          system clock, all state changes on the rising edge
//   reset          asynchronous, active-low
//   start          one-cycle pulse, accepted only in IDLE or DONE
//   num_cycles     cycle budget, sampled on an accepted start (0 = DEFAULT_CYCLES)
//   proc_readRegA  read-port-A index requested by the processor
//   ctrl_readRegA  index actually driven to regfile read port A
//   data_readRegA  regfile port A data (combinational from ctrl_readRegA)
//   proc_stall     1 = processor held (no PC advance, no regfile writes)
//   busy           1 while running or scanning
//   done           1 once the full dump has been delivered
//   cycle_count    unstalled cycles elapsed in the current run
//   dump_valid     dump beat valid
//   dump_ready     consumer accepts the beat
//   dump_reg       register index of the current beat
//   dump_data      register value of the current beat
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, processor stalled, waiting for start
// RUN       | processor unstalled, counting toward the budget
// SCAN_ADDR | scan index on read port A, capture data at the edge
// SCAN_OUT  | beat presented, hold until dump_valid & dump_ready
// DONE      | dump complete, processor stalled, start re-arms a run

module regfile_dump_ctrl #(
  parameter int CYCLE_W        = 8,
  parameter int DEFAULT_CYCLES = 255,
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = 5,
  parameter int DATA_W         = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] num_cycles,
  input  logic [REG_AW-1:0]  proc_readRegA,
  output logic [REG_AW-1:0]  ctrl_readRegA,
  input  logic [DATA_W-1:0]  data_readRegA,
  output logic               proc_stall,
  output logic               busy,
  output logic               done,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [REG_AW-1:0]  dump_reg,
  output logic [DATA_W-1:0]  dump_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SCAN_ADDR,
    S_SCAN_OUT,
    S_DONE
  } state_t;

  localparam logic [CYCLE_W-1:0] DEF_BUDGET = CYCLE_W'(DEFAULT_CYCLES);
  localparam logic [REG_AW-1:0]  LAST_IDX   = REG_AW'(NUM_REGS - 1);

  state_t             state;
  logic [CYCLE_W-1:0] budget;
  logic [REG_AW-1:0]  scan_idx;

  // Read port A belongs to the scanner only while a dump is in progress.
  always_comb begin
    ctrl_readRegA = proc_readRegA;
    if (state == S_SCAN_ADDR || state == S_SCAN_OUT)
      ctrl_readRegA = scan_idx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      proc_stall  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      budget      <= '0;
      scan_idx    <= '0;
      dump_valid  <= 1'b0;
      dump_reg    <= '0;
      dump_data   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            budget      <= (num_cycles == '0) ? DEF_BUDGET : num_cycles;
            cycle_count <= '0;
            proc_stall  <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= S_RUN;
          end
        end

        S_RUN: begin
          // The final increment leaves cycle_count equal to the budget,
          // so the processor sees exactly budget unstalled cycles.
          cycle_count <= cycle_count + CYCLE_W'(1);
          if (cycle_count == budget - CYCLE_W'(1)) begin
            proc_stall <= 1'b1;
            scan_idx   <= '0;
            state      <= S_SCAN_ADDR;
          end
        end

        S_SCAN_ADDR: begin
          dump_data  <= data_readRegA;
          dump_reg   <= scan_idx;
          dump_valid <= 1'b1;
          state      <= S_SCAN_OUT;
        end

        S_SCAN_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (scan_idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              scan_idx <= scan_idx + REG_AW'(1);
              state    <= S_SCAN_ADDR;
            end
          end
        end

        default: begin
          proc_stall <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          dump_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl
// Scoreboard bench for regfile_dump_ctrl. Every accepted start pushes the
// expected budget and the 32 expected (index, value) beats. A monitor on
// the falling edge pops and compares them whenever a handshake is about to
// happen. It also checks that beats stay stable under backpressure, that
// the unstalled cycle count and cycle_count match the budget, and that
// read port A follows the processor while it runs.

module tb_regfile_dump_ctrl;

  localparam int CYCLE_W  = 8;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [CYCLE_W-1:0] num_cycles = '0;
  logic [REG_AW-1:0]  proc_readRegA = 5'd9;
  logic [REG_AW-1:0]  ctrl_readRegA;
  logic [DATA_W-1:0]  data_readRegA;
  logic               proc_stall;
  logic               busy;
  logic               done;
  logic [CYCLE_W-1:0] cycle_count;
  logic               dump_valid;
  logic               dump_ready = 1'b1;
  logic [REG_AW-1:0]  dump_reg;
  logic [DATA_W-1:0]  dump_data;

  logic [DATA_W-1:0] rf [NUM_REGS];
  assign data_readRegA = rf[ctrl_readRegA];

  regfile_dump_ctrl #(
    .CYCLE_W(CYCLE_W), .DEFAULT_CYCLES(255), .NUM_REGS(NUM_REGS),
    .REG_AW(REG_AW), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .proc_readRegA(proc_readRegA), .ctrl_readRegA(ctrl_readRegA),
    .data_readRegA(data_readRegA), .proc_stall(proc_stall), .busy(busy),
    .done(done), .cycle_count(cycle_count), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_reg(dump_reg), .dump_data(dump_data)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_mis = 0;

  logic [REG_AW+DATA_W-1:0] beat_q [$];
  int                       bud_q  [$];

  bit rnd_ready = 1'b0;
  bit hold_low  = 1'b0;
  bit rnd_proc  = 1'b0;
  bit full_rate = 1'b0;

  int               cyc = 0;
  int               run_cnt = 0;
  int               run_end_cyc = 0;
  bit               prev_done = 1'b0;
  bit               prev_stall = 1'b1;
  bit               held_v = 1'b0;
  logic [REG_AW-1:0] held_reg;
  logic [DATA_W-1:0] held_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input drivers: dump_ready and the processor's read index change just
  // after each rising edge.
  always @(posedge clock) begin
    #1;
    if (hold_low)       dump_ready = 1'b0;
    else if (rnd_ready) dump_ready = 1'($urandom_range(0, 1));
    else                dump_ready = 1'b1;
    if (rnd_proc) proc_readRegA = REG_AW'($urandom);
  end

  // Monitor
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (!proc_stall) begin
        run_cnt++;
        chk("ctrl_mux_run", 64'(ctrl_readRegA), 64'(proc_readRegA));
      end
      if (held_v) begin
        chk("hold_valid", 64'(dump_valid), 64'd1);
        chk("hold_reg", 64'(dump_reg), 64'(held_reg));
        chk("hold_data", 64'(dump_data), 64'(held_data));
      end
      held_v = 1'b0;
      if (dump_valid) begin
        if (beat_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_beat actual=reg%0d expected=none at %0t", dump_reg, $time);
        end else if (dump_ready) begin
          logic [REG_AW+DATA_W-1:0] b;
          b = beat_q.pop_front();
          chk("beat_reg", 64'(dump_reg), 64'(b[REG_AW+DATA_W-1:DATA_W]));
          chk("beat_data", 64'(dump_data), 64'(b[DATA_W-1:0]));
        end else begin
          held_v    = 1'b1;
          held_reg  = dump_reg;
          held_data = dump_data;
        end
      end
      if (!prev_stall && proc_stall) run_end_cyc = cyc;
      if (done && !prev_done) begin
        if (bud_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
        end else begin
          int bud;
          bud = bud_q.pop_front();
          chk("unstalled_cycles", 64'(run_cnt), 64'(bud));
          chk("cycle_count_final", 64'(cycle_count), 64'(bud));
          chk("beats_left", 64'(beat_q.size()), 64'd0);
          if (full_rate) chk("done_latency", 64'(cyc - run_end_cyc), 64'(2 * NUM_REGS));
        end
        run_cnt = 0;
      end
      prev_done  = done;
      prev_stall = proc_stall;
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clock);
    #1;
    start      = 1'b1;
    num_cycles = CYCLE_W'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic do_run(input int n);
    for (int i = 0; i < NUM_REGS; i++)
      beat_q.push_back({REG_AW'(i), rf[i]});
    bud_q.push_back((n == 0) ? 255 : n);
    pulse_start(n);
  endtask

  task automatic wait_done(input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (done) found = 1'b1;
    end
    chk("done_reached", 64'(found), 64'd1);
    @(negedge clock);
  endtask

  task automatic wait_beat(input int idx, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (dump_valid && dump_reg == REG_AW'(idx)) found = 1'b1;
    end
    chk("beat_reached", 64'(found), 64'd1);
  endtask

  task automatic preload_x3();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i * 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preload_x3();

    // 1: reset state
    repeat (3) @(negedge clock);
    chk("rst_stall_in_reset", 64'(proc_stall), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_stall", 64'(proc_stall), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(dump_valid), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("rst_ctrl_mux", 64'(ctrl_readRegA), 64'd9);
    rnd_proc = 1'b1;

    // 2: budget 5, full rate, done latency 64
    full_rate = 1'b1;
    do_run(5);
    wait_done(400);
    full_rate = 1'b0;

    // 3: num_cycles 0 -> default budget
    do_run(0);
    wait_done(1000);

    // 4: backpressure on reg 7
    do_run(3);
    wait_beat(6, 200);
    hold_low = 1'b1;
    wait_beat(7, 20);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      chk("bp_valid", 64'(dump_valid), 64'd1);
      chk("bp_reg", 64'(dump_reg), 64'd7);
      chk("bp_data", 64'(dump_data), 64'd21);
    end
    hold_low = 1'b0;
    wait_done(400);

    // 5: start ignored mid-RUN and mid-scan; restart from DONE
    do_run(10);
    repeat (3) @(posedge clock);
    pulse_start(99);
    wait_beat(4, 200);
    pulse_start(7);
    wait_done(400);
    do_run(2);
    wait_done(400);

    // random runs with random contents and random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int n;
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
      n = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(1, 20);
      do_run(n);
      if ($urandom_range(0, 1) == 1) pulse_start($urandom_range(0, 255));
      wait_done(2000);
    end
    rnd_ready = 1'b0;

    // 6: async reset during SCAN_OUT of reg 12
    preload_x3();
    do_run(4);
    wait_beat(11, 200);
    hold_low = 1'b1;
    wait_beat(12, 20);
    #2;
    reset = 1'b0;
    beat_q.delete();
    bud_q.delete();
    #1;
    chk("arst_stall", 64'(proc_stall), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_valid", 64'(dump_valid), 64'd0);
    chk("arst_cycle_count", 64'(cycle_count), 64'd0);
    chk("arst_reg", 64'(dump_reg), 64'd0);
    chk("arst_data", 64'(dump_data), 64'd0);
    repeat (2) @(negedge clock);
    held_v     = 1'b0;
    prev_done  = 1'b0;
    prev_stall = 1'b1;
    run_cnt    = 0;
    hold_low   = 1'b0;
    reset      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("post_rst_no_valid", 64'(dump_valid), 64'd0);
    end
    chk("post_rst_busy", 64'(busy), 64'd0);

    // clean run after the reset
    do_run(3);
    wait_done(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
